// File: rtl/fetch_stage.sv
// Instruction fetch stage: walks the PC through a combinational ROM, hands words to
// decode with a valid/ready handshake, and stops permanently on a range or alignment error.
module fetch_stage #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           ROM_BYTES  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [DATA_WIDTH-1:0] pc_out,
    input  logic [DATA_WIDTH-1:0] rom_dout,
    input  logic                  pc_src,
    input  logic [DATA_WIDTH-1:0] pc_target,
    input  logic                  id_ready,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    output logic                  halted
);

    localparam logic [DATA_WIDTH-1:0] LAST_PC  = DATA_WIDTH'(ROM_BYTES - 32'd4);
    localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(32'd4);
    localparam logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t                r_state,  w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pc,     w_pc_nxt;
    logic [DATA_WIDTH-1:0] r_instr,  w_instr_nxt;
    logic [DATA_WIDTH-1:0] r_ipc,    w_ipc_nxt;
    logic                  r_valid,  w_valid_nxt;
    logic                  r_halted, w_halted_nxt;
    logic                  w_advance;

    assign w_advance = (!r_valid || id_ready) && !pc_src;

    // Next-state and next-output decode; a completed transfer drops valid unless refilled.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_ipc_nxt    = r_ipc;
        w_valid_nxt  = r_valid && !id_ready;
        w_halted_nxt = r_halted;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (pc_src) begin
                    w_valid_nxt = 1'b0;
                    if (pc_target[1:0] != 2'b00) begin
                        w_state_nxt  = ST_HALTED;
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_pc_nxt = pc_target;
                    end
                end else if (w_advance) begin
                    if (r_pc > LAST_PC) begin
                        w_state_nxt  = ST_HALTED;
                        w_halted_nxt = 1'b1;
                    end else begin
                        w_instr_nxt = rom_dout;
                        w_ipc_nxt   = r_pc;
                        w_valid_nxt = 1'b1;
                        w_pc_nxt    = r_pc + PC_STEP;
                    end
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_pc     <= RESET_PC;
            r_instr  <= NOP_WORD;
            r_ipc    <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_ipc    <= w_ipc_nxt;
            r_valid  <= w_valid_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    assign pc_out      = r_pc;
    assign instr_out   = r_instr;
    assign instr_pc    = r_ipc;
    assign instr_valid = r_valid;
    assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written halt/reset sequences,
// and a randomized run against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam int unsigned ROM_BYTES = 32;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] rom_dout;
    logic        pc_src = 1'b0;
    logic [31:0] pc_target = '0;
    logic        id_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        halted;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] rom_mem [0:31];
    logic [4:0] w_k;

    fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0), .ROM_BYTES(ROM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n), .pc_out(pc_out), .rom_dout(rom_dout),
        .pc_src(pc_src), .pc_target(pc_target), .id_ready(id_ready),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Big-endian combinational ROM; out-of-range reads return a recognisable junk word.
    assign w_k = pc_out[4:0];
    assign rom_dout = (pc_out <= 32'd28) ?
        {rom_mem[w_k], rom_mem[w_k + 5'd1], rom_mem[w_k + 5'd2], rom_mem[w_k + 5'd3]} :
        (32'hBAD0_0000 | pc_out);

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [4:0] k;
        k = a[4:0];
        if (a <= 32'd28 && a[1:0] == 2'b00)
            return {rom_mem[k], rom_mem[k + 5'd1], rom_mem[k + 5'd2], rom_mem[k + 5'd3]};
        return 32'hBAD0_0000 | a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                                 input logic [31:0] e_ipc, input logic e_valid, input logic e_halt);
        chk({tag, ".pc_out"}, pc_out, e_pc);
        chk({tag, ".instr_out"}, instr_out, e_instr);
        chk({tag, ".instr_pc"}, instr_pc, e_ipc);
        chk({tag, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, e_valid});
        chk({tag, ".halted"}, {31'b0, halted}, {31'b0, e_halt});
    endtask

    // Behavioural model: what the fetch unit should show after each clock edge.
    logic [31:0] m_pc, m_instr, m_ipc;
    bit          m_valid, m_halted, m_started, m_stopped;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0;
        m_valid = 0; m_halted = 0; m_started = 0; m_stopped = 0;
    endtask

    task automatic model_step(input bit src, input logic [31:0] tgt, input bit rdy);
        bit consumed;
        consumed = m_valid && rdy;
        if (!m_started) begin
            m_started = 1;
        end else if (m_stopped) begin
            if (consumed) m_valid = 0;
        end else if (src) begin
            m_valid = 0;
            if (tgt % 4 != 0) begin
                m_stopped = 1; m_halted = 1;
            end else begin
                m_pc = tgt;
            end
        end else if (!m_valid || rdy) begin
            if (longint'(m_pc) + 4 > longint'(ROM_BYTES)) begin
                m_stopped = 1; m_halted = 1; m_valid = 0;
            end else begin
                m_instr = word_at(m_pc); m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Drive inputs just after a falling edge, then wait for the next falling edge.
    task automatic cycle(input bit src, input logic [31:0] tgt, input bit rdy);
        pc_src = src; pc_target = tgt; id_ready = rdy;
        @(negedge clk);
    endtask

    task automatic do_reset(input bit new_rom);
        rst_n = 1'b0;
        if (new_rom) for (int k = 0; k < 32; k++) rom_mem[k] = 8'($urandom);
        #1;
        check_outputs("reset", 32'h0, NOP, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit          src;
        logic [31:0] tgt;
        bit          rdy;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_ipc;
        bit          e_halt;
        bit          e_nop;
    } vec_t;

    function automatic vec_t mk(input bit src, input logic [31:0] tgt, input bit rdy, input bit ev,
                                input logic [31:0] epc, input logic [31:0] eipc, input bit eh, input bit enop);
        vec_t v;
        v.src = src; v.tgt = tgt; v.rdy = rdy; v.e_valid = ev;
        v.e_pc = epc; v.e_ipc = eipc; v.e_halt = eh; v.e_nop = enop;
        return v;
    endfunction

    vec_t tbl [20];

    initial begin
        int halt_age;
        bit          r_src;
        logic [31:0] r_tgt;
        bit          r_rdy;

        // Sequential fill, backpressure, redirects, run-off past the ROM end.
        tbl[0]  = mk(0, 0, 1, 0, 32'd0,  32'd0,  0, 1);
        tbl[1]  = mk(0, 0, 1, 1, 32'd4,  32'd0,  0, 0);
        tbl[2]  = mk(0, 0, 1, 1, 32'd8,  32'd4,  0, 0);
        tbl[3]  = mk(0, 0, 1, 1, 32'd12, 32'd8,  0, 0);
        tbl[4]  = mk(0, 0, 1, 1, 32'd16, 32'd12, 0, 0);
        tbl[5]  = mk(0, 0, 0, 1, 32'd16, 32'd12, 0, 0);
        tbl[6]  = mk(0, 0, 0, 1, 32'd16, 32'd12, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 32'd16, 32'd12, 0, 0);
        tbl[8]  = mk(0, 0, 1, 1, 32'd20, 32'd16, 0, 0);
        tbl[9]  = mk(1, 4, 0, 0, 32'd4,  32'd16, 0, 0);
        tbl[10] = mk(0, 0, 0, 1, 32'd8,  32'd4,  0, 0);
        tbl[11] = mk(1, 16, 0, 0, 32'd16, 32'd4, 0, 0);
        tbl[12] = mk(0, 0, 0, 1, 32'd20, 32'd16, 0, 0);
        tbl[13] = mk(0, 0, 1, 1, 32'd24, 32'd20, 0, 0);
        tbl[14] = mk(0, 0, 1, 1, 32'd28, 32'd24, 0, 0);
        tbl[15] = mk(0, 0, 1, 1, 32'd32, 32'd28, 0, 0);
        tbl[16] = mk(0, 0, 0, 1, 32'd32, 32'd28, 0, 0);
        tbl[17] = mk(0, 0, 0, 1, 32'd32, 32'd28, 0, 0);
        tbl[18] = mk(0, 0, 1, 0, 32'd32, 32'd28, 1, 0);
        tbl[19] = mk(1, 0, 1, 0, 32'd32, 32'd28, 1, 0);

        for (int k = 0; k < 32; k++) rom_mem[k] = 8'(k * 37 + 11);
        @(negedge clk);
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].src, tbl[i].tgt, tbl[i].rdy);
            check_outputs($sformatf("vec%0d", i), tbl[i].e_pc,
                          tbl[i].e_nop ? NOP : word_at(tbl[i].e_ipc),
                          tbl[i].e_ipc, tbl[i].e_valid, tbl[i].e_halt);
        end

        // Misaligned redirect halts; later redirects are ignored.
        do_reset(1'b0);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        check_outputs("mis_pre", 32'd4, word_at(32'd0), 32'd0, 1'b1, 1'b0);
        cycle(1, 32'd6, 0);
        check_outputs("mis_halt", 32'd4, word_at(32'd0), 32'd0, 1'b0, 1'b1);
        cycle(1, 32'd8, 1);
        cycle(1, 32'd12, 0);
        check_outputs("mis_ignore", 32'd4, word_at(32'd0), 32'd0, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle while halted, then restart from the reset PC.
        pc_src = 0; id_ready = 1;
        #1 rst_n = 1'b0;
        #1 check_outputs("async_rst", 32'd0, NOP, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 1);
        check_outputs("restart_e1", 32'd0, NOP, 32'd0, 1'b0, 1'b0);
        cycle(0, 0, 1);
        check_outputs("restart_e2", 32'd4, word_at(32'd0), 32'd0, 1'b1, 1'b0);

        // Randomized run against the model, resetting a while after each halt.
        do_reset(1'b1);
        halt_age = 0;
        for (int c = 0; c < 3000; c++) begin
            if (m_stopped && halt_age > 4) begin
                do_reset(1'b1);
                halt_age = 0;
            end
            r_src = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) r_tgt = 32'($urandom_range(0, 40));
            else                           r_tgt = 32'($urandom_range(0, 9)) * 32'd4;
            r_rdy = ($urandom_range(0, 3) != 0);
            model_step(r_src, r_tgt, r_rdy);
            cycle(r_src, r_tgt, r_rdy);
            check_outputs("rand", m_pc, m_instr, m_ipc, m_valid, m_halted);
            if (m_stopped) halt_age++;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
